// File: rtl/wt_cache_pkg.sv
// Shared helpers for the write-through cache memory-side arbiter:
// port-index width and tagged transaction-ID packing/unpacking.
package wt_cache_pkg;

  localparam int unsigned WtMemMaxOutstanding = 4;

  function automatic int unsigned port_id_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Tags are {port, tid}; helpers work on 32-bit containers and callers truncate.
  function automatic logic [31:0] tag_pack(input logic [31:0] port,
                                           input logic [31:0] tid,
                                           input int unsigned tid_w);
    return (port << tid_w) | (tid & ((32'd1 << tid_w) - 32'd1));
  endfunction

  function automatic logic [31:0] tag_port(input logic [31:0] tag, input int unsigned tid_w);
    return tag >> tid_w;
  endfunction

  function automatic logic [31:0] tag_tid(input logic [31:0] tag, input int unsigned tid_w);
    return tag & ((32'd1 << tid_w) - 32'd1);
  endfunction

endpackage

// File: rtl/wt_mem_rr_arbiter.sv
// Round-robin picker: one-hot grant for the first eligible port at or after
// the pointer (wrapping), pointer moves past the winner on advance.
module wt_mem_rr_arbiter #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned PtrW     = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] elig_i,
  input  logic                advance_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [PtrW-1:0]     win_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    // First pass covers ports at/after the pointer, second pass wraps around.
    for (int p = 0; p < NumPorts; p++) begin
      if (!found && elig_i[p] && (p >= int'(ptr_q))) begin
        found    = 1'b1;
        gnt_o[p] = 1'b1;
        win_o    = PtrW'(p);
      end
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (!found && elig_i[p]) begin
        found    = 1'b1;
        gnt_o[p] = 1'b1;
        win_o    = PtrW'(p);
      end
    end
    if (advance_i && found) begin
      ptr_d = (win_o == PtrW'(NumPorts - 1)) ? '0 : win_o + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wt_mem_port_arbiter.sv
// N-port memory-side arbiter: round-robin request merge with {port, tid}
// tagging, per-port outstanding limit, and tag-routed registered returns.
module wt_mem_port_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RtrnWidth      = 128,
  parameter int unsigned TxIdWidth      = 2,
  parameter int unsigned MaxOutstanding = WtMemMaxOutstanding,
  localparam int unsigned PortIdW       = port_id_w(NumPorts),
  localparam int unsigned TagW          = PortIdW + TxIdWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 port_req_i,
  input  logic [NumPorts-1:0][ReqWidth-1:0]   port_data_i,
  input  logic [NumPorts-1:0][TxIdWidth-1:0]  port_tid_i,
  output logic [NumPorts-1:0]                 port_ack_o,
  output logic [NumPorts-1:0]                 port_rtrn_vld_o,
  output logic [RtrnWidth-1:0]                port_rtrn_data_o,
  output logic [TxIdWidth-1:0]                port_rtrn_tid_o,
  output logic                                mem_req_o,
  output logic [ReqWidth-1:0]                 mem_data_o,
  output logic [TagW-1:0]                     mem_tid_o,
  input  logic                                mem_ack_i,
  input  logic                                mem_rtrn_vld_i,
  input  logic [RtrnWidth-1:0]                mem_rtrn_data_i,
  input  logic [TagW-1:0]                     mem_rtrn_tid_i,
  input  logic                                mem_rtrn_last_i,
  output logic                                idle_o,
  output logic                                err_unexp_rtrn_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [NumPorts-1:0]           elig, gnt, rtrn_hit, rtrn_zero;
  logic [NumPorts-1:0][CntW-1:0] cnt;
  logic [PortIdW-1:0]            win_idx, rtrn_port;
  logic [TxIdWidth-1:0]          rtrn_tid;
  logic                          rtrn_port_ok, capture;

  logic                 mem_vld_q, mem_vld_d;
  logic [ReqWidth-1:0]  mem_data_q, mem_data_d;
  logic [TagW-1:0]      mem_tid_q, mem_tid_d;
  logic [NumPorts-1:0]  rtrn_vld_q;
  logic [RtrnWidth-1:0] rtrn_data_q;
  logic [TxIdWidth-1:0] rtrn_tid_q;
  logic                 err_q, err_d;

  assign rtrn_port    = PortIdW'(tag_port(32'(mem_rtrn_tid_i), TxIdWidth));
  assign rtrn_tid     = TxIdWidth'(tag_tid(32'(mem_rtrn_tid_i), TxIdWidth));
  assign rtrn_port_ok = (32'(rtrn_port) < NumPorts);

  // The output stage refills on the same cycle it drains, giving one request per cycle.
  assign capture    = !mem_vld_q || mem_ack_i;
  assign port_ack_o = capture ? gnt : '0;

  wt_mem_rr_arbiter #(
    .NumPorts (NumPorts),
    .PtrW     (PortIdW)
  ) i_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .elig_i    (elig),
    .advance_i (capture),
    .gnt_o     (gnt),
    .win_o     (win_idx)
  );

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            inc, dec;

    assign rtrn_hit[gi]  = mem_rtrn_vld_i && (rtrn_port == PortIdW'(gi));
    assign rtrn_zero[gi] = rtrn_hit[gi] && (cnt_q == '0);
    assign inc           = port_ack_o[gi];
    assign dec           = rtrn_hit[gi] && mem_rtrn_last_i && (cnt_q != '0);
    assign elig[gi]      = port_req_i[gi] && (cnt_q < CntW'(MaxOutstanding));
    assign cnt[gi]       = cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + CntW'(1);
      else if (dec && !inc) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end

  always_comb begin
    mem_vld_d  = mem_vld_q;
    mem_data_d = mem_data_q;
    mem_tid_d  = mem_tid_q;
    if (capture) begin
      mem_vld_d = |gnt;
      for (int p = 0; p < NumPorts; p++) begin
        if (gnt[p]) begin
          mem_data_d = port_data_i[p];
          mem_tid_d  = TagW'(tag_pack(32'(win_idx), 32'(port_tid_i[p]), TxIdWidth));
        end
      end
    end
  end

  // A last-return nobody is waiting for is flagged but never touches a counter.
  assign err_d = err_q | (mem_rtrn_vld_i & mem_rtrn_last_i & (~rtrn_port_ok | (|rtrn_zero)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_vld_q   <= 1'b0;
      mem_data_q  <= '0;
      mem_tid_q   <= '0;
      rtrn_vld_q  <= '0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_vld_q  <= mem_vld_d;
      mem_data_q <= mem_data_d;
      mem_tid_q  <= mem_tid_d;
      rtrn_vld_q <= rtrn_hit;
      if (mem_rtrn_vld_i) begin
        rtrn_data_q <= mem_rtrn_data_i;
        rtrn_tid_q  <= rtrn_tid;
      end
      err_q <= err_d;
    end
  end

  assign mem_req_o        = mem_vld_q;
  assign mem_data_o       = mem_data_q;
  assign mem_tid_o        = mem_tid_q;
  assign port_rtrn_vld_o  = rtrn_vld_q;
  assign port_rtrn_data_o = rtrn_data_q;
  assign port_rtrn_tid_o  = rtrn_tid_q;
  assign err_unexp_rtrn_o = err_q;
  assign idle_o           = !mem_vld_q && (cnt == '0);

endmodule

// File: tb/tb_wt_mem_port_arbiter.sv
// Bench for wt_mem_port_arbiter: directed vector table, hand-built corner
// sequences, then random traffic against a rule-level reference model.
module tb_wt_mem_port_arbiter;

  localparam int N    = 3;
  localparam int RW   = 16;
  localparam int TW   = 2;
  localparam int MAXO = 2;
  localparam int TAGW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          port_req;
  logic [N-1:0][RW-1:0]  port_data;
  logic [N-1:0][TW-1:0]  port_tid;
  logic [N-1:0]          port_ack;
  logic [N-1:0]          rtrn_vld;
  logic [RW-1:0]         rtrn_data;
  logic [TW-1:0]         rtrn_tid;
  logic                  mem_req;
  logic [RW-1:0]         mem_data;
  logic [TAGW-1:0]       mem_tid;
  logic                  mem_ack;
  logic                  mem_rtrn_vld;
  logic [RW-1:0]         mem_rtrn_data;
  logic [TAGW-1:0]       mem_rtrn_tid;
  logic                  mem_rtrn_last;
  logic                  idle;
  logic                  err;

  wt_mem_port_arbiter #(
    .NumPorts       (N),
    .ReqWidth       (RW),
    .RtrnWidth      (RW),
    .TxIdWidth      (TW),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .port_req_i       (port_req),
    .port_data_i      (port_data),
    .port_tid_i       (port_tid),
    .port_ack_o       (port_ack),
    .port_rtrn_vld_o  (rtrn_vld),
    .port_rtrn_data_o (rtrn_data),
    .port_rtrn_tid_o  (rtrn_tid),
    .mem_req_o        (mem_req),
    .mem_data_o       (mem_data),
    .mem_tid_o        (mem_tid),
    .mem_ack_i        (mem_ack),
    .mem_rtrn_vld_i   (mem_rtrn_vld),
    .mem_rtrn_data_i  (mem_rtrn_data),
    .mem_rtrn_tid_i   (mem_rtrn_tid),
    .mem_rtrn_last_i  (mem_rtrn_last),
    .idle_o           (idle),
    .err_unexp_rtrn_o (err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pd(input int p, input int t);
    return 16'hD000 | 16'(p << 8) | 16'(t);
  endfunction

  task automatic set_inputs(input logic [N-1:0] req, input logic [TW-1:0] tid, input logic mack,
                            input logic rv, input logic [TAGW-1:0] rtag, input logic rlast);
    port_req = req;
    for (int p = 0; p < N; p++) begin
      port_data[p] = pd(p, int'(tid));
      port_tid[p]  = tid;
    end
    mem_ack       = mack;
    mem_rtrn_vld  = rv;
    mem_rtrn_tid  = rtag;
    mem_rtrn_last = rlast;
    mem_rtrn_data = 16'hE000 | 16'(rtag);
  endtask

  // Drive 2 time units after the rising edge, leave outputs 2 more units to settle.
  task automatic drive(input logic [N-1:0] req, input logic [TW-1:0] tid, input logic mack,
                       input logic rv, input logic [TAGW-1:0] rtag, input logic rlast);
    @(posedge clk);
    #2;
    set_inputs(req, tid, mack, rv, rtag, rlast);
    #2;
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [TW-1:0]   tid;
    logic            mack;
    logic            rv;
    logic [TAGW-1:0] rtag;
    logic            rlast;
    logic [N-1:0]    e_ack;
    logic            e_mreq;
    logic [TAGW-1:0] e_mtid;
    logic [N-1:0]    e_rvld;
    logic [TW-1:0]   e_rtid;
    logic            e_err;
    logic            e_idle;
  } vec_t;

  vec_t tbl[19];

  // Reference model state
  int            md_cnt[N];
  int            md_ptr;
  bit            md_valid;
  logic [RW-1:0] md_data;
  logic [3:0]    md_tid;
  logic [N-1:0]  md_rv;
  logic [TW-1:0] md_rtid;
  logic [RW-1:0] md_rdata;
  bit            md_err;
  bit            md_idle;
  bit            preq[N];
  logic [RW-1:0] pdat[N];
  logic [TW-1:0] ptid[N];
  int            win, rp;
  bit            cap;
  logic [N-1:0]  exp_ack;

  task automatic do_reset();
    @(posedge clk);
    #3;
    set_inputs('0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst idle", idle, 1'b1);
    chk("rst err", err, 1'b0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_tid", mem_tid, 0);
    chk("rst rtrn_vld", rtrn_vld, 0);
    chk("rst rtrn_tid", rtrn_tid, 0);
    chk("rst ack", port_ack, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_inputs('0, '0, 1'b0, 1'b0, '0, 1'b0);
    //             req   tid  mk rv rtag   l   ack   mq mtid   rvld   rtid err idle
    tbl[0]  = '{3'b000, 2'd0, 0, 0, 4'd0,  0, 3'b000, 0, 4'd0, 3'b000, 2'd0, 0, 1};
    tbl[1]  = '{3'b010, 2'd2, 1, 0, 4'd0,  0, 3'b010, 0, 4'd0, 3'b000, 2'd0, 0, 1};
    tbl[2]  = '{3'b000, 2'd0, 1, 0, 4'd0,  0, 3'b000, 1, 4'd6, 3'b000, 2'd0, 0, 0};
    tbl[3]  = '{3'b000, 2'd0, 1, 1, 4'd6,  1, 3'b000, 0, 4'd0, 3'b000, 2'd0, 0, 0};
    tbl[4]  = '{3'b000, 2'd0, 0, 0, 4'd0,  0, 3'b000, 0, 4'd0, 3'b010, 2'd2, 0, 1};
    tbl[5]  = '{3'b100, 2'd0, 1, 0, 4'd0,  0, 3'b100, 0, 4'd0, 3'b000, 2'd0, 0, 1};
    tbl[6]  = '{3'b000, 2'd0, 1, 1, 4'd8,  1, 3'b000, 1, 4'd8, 3'b000, 2'd0, 0, 0};
    tbl[7]  = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b001, 0, 4'd0, 3'b100, 2'd0, 0, 1};
    tbl[8]  = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b010, 1, 4'd1, 3'b000, 2'd0, 0, 0};
    tbl[9]  = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b100, 1, 4'd5, 3'b000, 2'd0, 0, 0};
    tbl[10] = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b001, 1, 4'd9, 3'b000, 2'd0, 0, 0};
    tbl[11] = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b010, 1, 4'd1, 3'b000, 2'd0, 0, 0};
    tbl[12] = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b100, 1, 4'd5, 3'b000, 2'd0, 0, 0};
    tbl[13] = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b000, 1, 4'd9, 3'b000, 2'd0, 0, 0};
    tbl[14] = '{3'b111, 2'd1, 1, 1, 4'd3,  1, 3'b000, 0, 4'd0, 3'b000, 2'd0, 0, 0};
    tbl[15] = '{3'b111, 2'd1, 1, 0, 4'd0,  0, 3'b001, 0, 4'd0, 3'b001, 2'd3, 0, 0};
    tbl[16] = '{3'b000, 2'd0, 1, 1, 4'd11, 0, 3'b000, 1, 4'd1, 3'b000, 2'd0, 0, 0};
    tbl[17] = '{3'b000, 2'd0, 1, 1, 4'd12, 1, 3'b000, 0, 4'd0, 3'b100, 2'd3, 0, 0};
    tbl[18] = '{3'b000, 2'd0, 0, 0, 4'd0,  0, 3'b000, 0, 4'd0, 3'b000, 2'd0, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("init idle", idle, 1'b1);
    chk("init mem_req", mem_req, 1'b0);
    chk("init err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].req, tbl[i].tid, tbl[i].mack, tbl[i].rv, tbl[i].rtag, tbl[i].rlast);
      chk($sformatf("v%0d ack", i), port_ack, tbl[i].e_ack);
      chk($sformatf("v%0d mem_req", i), mem_req, tbl[i].e_mreq);
      if (tbl[i].e_mreq) begin
        chk($sformatf("v%0d mem_tid", i), mem_tid, tbl[i].e_mtid);
        chk($sformatf("v%0d mem_data", i), mem_data,
            pd(int'(tbl[i].e_mtid[3:2]), int'(tbl[i].e_mtid[1:0])));
      end
      chk($sformatf("v%0d rtrn_vld", i), rtrn_vld, tbl[i].e_rvld);
      if (tbl[i].e_rvld != 0) chk($sformatf("v%0d rtrn_tid", i), rtrn_tid, tbl[i].e_rtid);
      chk($sformatf("v%0d err", i), err, tbl[i].e_err);
      chk($sformatf("v%0d idle", i), idle, tbl[i].e_idle);
      $display("vec %0d: req=%b ack=%b mem_req=%b mem_tid=%0h rtrn_vld=%b err=%b idle=%b",
               i, tbl[i].req, port_ack, mem_req, mem_tid, rtrn_vld, err, idle);
    end

    // Asynchronous reset mid-stream clears the sticky error too
    do_reset();

    // Backpressure: stage full, mem_ack low for 5 cycles
    drive(3'b001, 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("bp first ack", port_ack, 3'b001);
    for (int i = 0; i < 5; i++) begin
      drive(3'b011, 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);
      chk($sformatf("bp%0d ack", i), port_ack, 3'b000);
      chk($sformatf("bp%0d mem_req", i), mem_req, 1'b1);
      chk($sformatf("bp%0d mem_tid", i), mem_tid, 4'd3);
      chk($sformatf("bp%0d mem_data", i), mem_data, pd(0, 3));
      $display("bp cycle %0d: mem_req=%b mem_tid=%0h ack=%b", i, mem_req, mem_tid, port_ack);
    end
    drive(3'b011, 2'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("bp release ack", port_ack, 3'b010);
    // Simultaneous ack and last-return on port0 with cnt=1
    drive(3'b001, 2'd3, 1'b1, 1'b1, 4'd3, 1'b1);
    chk("incdec ack", port_ack, 3'b001);
    chk("incdec mem_tid", mem_tid, 4'd7);
    drive(3'b001, 2'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("incdec second ack", port_ack, 3'b001);
    chk("incdec rtrn_vld", rtrn_vld, 3'b001);
    drive(3'b001, 2'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("full no ack", port_ack, 3'b000);
    // Free-after-complete: freed slot counts only from the next cycle
    drive(3'b001, 2'd3, 1'b1, 1'b1, 4'd3, 1'b1);
    chk("free same-cycle no ack", port_ack, 3'b000);
    drive(3'b001, 2'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("free next-cycle ack", port_ack, 3'b001);
    $display("corner sequences done: ack=%b err=%b", port_ack, err);

    // Random traffic against the reference model
    do_reset();
    for (int p = 0; p < N; p++) begin
      md_cnt[p] = 0;
      preq[p]   = 1'b0;
      pdat[p]   = '0;
      ptid[p]   = '0;
    end
    md_ptr = 0; md_valid = 1'b0; md_data = '0; md_tid = '0;
    md_rv = '0; md_rtid = '0; md_rdata = '0; md_err = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #2;
      for (int p = 0; p < N; p++) begin
        if (!preq[p] && ($urandom_range(0, 2) != 0)) begin
          preq[p] = 1'b1;
          pdat[p] = RW'($urandom);
          ptid[p] = TW'($urandom);
        end
        port_req[p]  = preq[p];
        port_data[p] = pdat[p];
        port_tid[p]  = ptid[p];
      end
      mem_ack      = ($urandom_range(0, 3) != 0);
      mem_rtrn_vld = 1'($urandom_range(0, 1));
      rp           = int'($urandom_range(0, N - 1));
      if (cyc > 500 && $urandom_range(0, 19) == 0) rp = 3;
      mem_rtrn_last = 1'($urandom_range(0, 1));
      if (cyc <= 500 && rp < N && md_cnt[rp] == 0) mem_rtrn_last = 1'b0;
      mem_rtrn_tid  = {2'(rp), TW'($urandom)};
      mem_rtrn_data = RW'($urandom);
      #2;

      md_idle = !md_valid;
      for (int p = 0; p < N; p++) if (md_cnt[p] != 0) md_idle = 1'b0;
      chk("rnd mem_req", mem_req, md_valid);
      if (md_valid) begin
        chk("rnd mem_data", mem_data, md_data);
        chk("rnd mem_tid", mem_tid, md_tid);
      end
      chk("rnd rtrn_vld", rtrn_vld, md_rv);
      if (md_rv != 0) begin
        chk("rnd rtrn_tid", rtrn_tid, md_rtid);
        chk("rnd rtrn_data", rtrn_data, md_rdata);
      end
      chk("rnd err", err, md_err);
      chk("rnd idle", idle, md_idle);

      // Winner: first requesting port below the limit, searching from the pointer
      cap = !md_valid || mem_ack;
      win = -1;
      if (cap) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && preq[(md_ptr + k) % N] && md_cnt[(md_ptr + k) % N] < MAXO)
            win = (md_ptr + k) % N;
        end
      end
      exp_ack = (win >= 0) ? N'(1 << win) : '0;
      chk("rnd ack", port_ack, exp_ack);

      if (cap) begin
        md_valid = (win >= 0);
        if (win >= 0) begin
          md_data = pdat[win];
          md_tid  = {2'(win), ptid[win]};
          md_ptr  = (win + 1) % N;
        end
      end
      if (mem_rtrn_vld) begin
        md_rv    = (rp < N) ? N'(1 << rp) : '0;
        md_rtid  = mem_rtrn_tid[TW-1:0];
        md_rdata = mem_rtrn_data;
        if (mem_rtrn_last) begin
          if (rp >= N || md_cnt[rp] == 0) md_err = 1'b1;
          else md_cnt[rp] = md_cnt[rp] - 1;
        end
      end else begin
        md_rv = '0;
      end
      if (win >= 0) begin
        md_cnt[win] = md_cnt[win] + 1;
        preq[win]   = 1'b0;
        $display("rnd cycle %0d: port %0d acked tid %0d data %04h", cyc, win, ptid[win], pdat[win]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
